adder_misr_compactor: RTL

//  BIST response compactor directly downstream of the N-bit ripple adder.

---
 rtl/adder_misr_compactor.sv | 77 +++++++
 1 files changed

// File: rtl/adder_misr_compactor.sv
// BIST response compactor: folds each {co,sum} adder result into an (N+1)-bit MISR
// for PATTERNS results, then flags whether the final signature matches golden.
module adder_misr_compactor #(
    parameter int unsigned N        = 16,
    parameter int unsigned PATTERNS = 256,
    parameter logic [N:0]  POLY     = 17'h04001,
    parameter logic [N:0]  SEED     = 17'h00000,
    localparam int unsigned CW      = $clog2(PATTERNS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [N-1:0]  sum,
    input  logic          co,
    input  logic [N:0]    golden,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [N:0]    signature,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CW-1:0] LastCount = CW'(PATTERNS - 1);

    state_e     state_q;
    logic [N:0] sig_next;

    // One MISR step: shift left, feed back the dropped MSB through POLY, fold in the result.
    always_comb begin
        sig_next = {signature[N-1:0], 1'b0} ^ (signature[N] ? POLY : '0) ^ {co, sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            signature <= SEED;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StRun;
                        signature <= SEED;
                        count     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                StRun: begin
                    if (in_valid) begin
                        signature <= sig_next;
                        count     <= count + 1'b1;
                        if (count == LastCount) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (sig_next == golden);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
